// File: rtl/btn_pkg.sv
// Shared types and helpers for the button input stage.
// Holds the latch FSM encoding and the one-hot test used on the debounced vector.
package btn_pkg;

    localparam int NUM_BTN = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REJECT = 2'd2
    } state_t;

    // True when exactly one bit is set; zero is not one-hot.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/button_onehot_latch_if.sv
// Button/display bundle: raw buttons and clear in, latched one-hot code and strobes out.
// master drives the buttons, slave is the latch.
interface button_onehot_latch_if;

    logic [7:0] btn;
    logic       clear;
    logic [7:0] dout;
    logic       valid;
    logic       press;

    modport master (
        output btn,
        output clear,
        input  dout,
        input  valid,
        input  press
    );

    modport slave (
        input  btn,
        input  clear,
        output dout,
        output valid,
        output press
    );

endinterface

// File: rtl/debounce_bit.sv
// One button: 2-FF synchronizer, then a level is accepted after DEBOUNCE_CYCLES
// consecutive cycles that disagree with the current stable level. No backpressure.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;

    assign w_mismatch = (r_sync != r_stable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Any agreeing cycle restarts qualification, so glitches never accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_mismatch) begin
            r_cnt    <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/button_onehot_latch.sv
// Debounces eight buttons and latches the last lone press as a one-hot code.
// Latency btn->dout is DEBOUNCE_CYCLES+3 cycles; all outputs registered, no backpressure.
module button_onehot_latch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    button_onehot_latch_if.slave  bus
);

    logic [NUM_BTN-1:0] w_stable;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_dout;
    logic [7:0]         w_dout_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_press;
    logic               w_press_nxt;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_btn    (bus.btn[gi]),
            .o_stable (w_stable[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dout  <= 8'h00;
            r_valid <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_press <= w_press_nxt;
        end
    end

    // Clear is applied first so a same-cycle capture overrides it.
    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_valid;
        w_press_nxt = 1'b0;

        if (bus.clear) begin
            w_dout_nxt  = 8'h00;
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (is_onehot(w_stable)) begin
                    w_dout_nxt  = w_stable;
                    w_valid_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_state_nxt = HELD;
                end else if (w_stable != 8'h00) begin
                    w_state_nxt = REJECT;
                end
            end
            HELD, REJECT: begin
                if (w_stable == 8'h00) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.dout  = r_dout;
    assign bus.valid = r_valid;
    assign bus.press = r_press;

endmodule

// File: tb/tb_button_onehot_latch.sv
// Directed bench for button_onehot_latch with DEBOUNCE_CYCLES=4; expected captures
// are queued with their due cycle and checked whenever press is seen.
module tb_button_onehot_latch;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    button_onehot_latch_if bus();

    button_onehot_latch #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard: every press must match the oldest queued capture in code and timing.
    always @(negedge clk) begin
        if (bus.press === 1'b1) begin
            n_vec++;
            assert (q.size() !== 0) else begin
                n_err++;
                $error("FAIL unexpected_press: cycle %0d dout=%h, no capture queued", cyc, bus.dout);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                assert (bus.dout === e.code) else begin
                    n_err++;
                    $error("FAIL press_dout: got %h want %h", bus.dout, e.code);
                end
                n_vec++;
                assert (bus.valid === 1'b1) else begin
                    n_err++;
                    $error("FAIL press_valid: got %b want 1", bus.valid);
                end
                n_vec++;
                assert (cyc === e.cyc) else begin
                    n_err++;
                    $error("FAIL press_cycle: got %0d want %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_expect(input logic [7:0] v, input logic [7:0] code);
        bus.btn = v;
        q.push_back('{code: code, cyc: cyc + LAT});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        n_vec++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_timeout: %0d captures outstanding, want 0", tag, q.size());
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v);
        n_vec++;
        assert (bus.dout === d) else begin
            n_err++;
            $error("FAIL %s_dout: got %h want %h", tag, bus.dout, d);
        end
        n_vec++;
        assert (bus.valid === v) else begin
            n_err++;
            $error("FAIL %s_valid: got %b want %b", tag, bus.valid, v);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.btn   = 8'h00;
        bus.clear = 1'b0;
        nedge(2);
        check_out("reset", 8'h00, 1'b0);
        n_vec++;
        assert (bus.press === 1'b0) else begin
            n_err++;
            $error("FAIL reset_press: got %b want 0", bus.press);
        end
        rst = 1'b0;
        nedge(2);

        // Clean press, then a different button after full release.
        drive_expect(8'h20, 8'h20);
        drain("clean20");
        nedge(1);
        check_out("clean20", 8'h20, 1'b1);
        bus.btn = 8'h00;
        nedge(10);
        check_out("release_keep", 8'h20, 1'b1);
        drive_expect(8'h01, 8'h01);
        drain("clean01");
        check_out("clean01", 8'h01, 1'b1);

        // Async reset mid-debounce of a new press; held button re-qualifies afterwards.
        bus.btn = 8'h00;
        nedge(10);
        bus.btn = 8'h20;
        nedge(3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 8'h00, 1'b0);
        n_vec++;
        assert (bus.press === 1'b0) else begin
            n_err++;
            $error("FAIL async_rst_press: got %b want 0", bus.press);
        end
        nedge(2);
        rst = 1'b0;
        q.push_back('{code: 8'h20, cyc: cyc + LAT});
        drain("post_rst");

        // Bounce on bit 4 before settling high.
        bus.btn = 8'h00;
        nedge(10);
        bus.btn = 8'h10; nedge(1);
        bus.btn = 8'h00; nedge(1);
        bus.btn = 8'h10; nedge(1);
        bus.btn = 8'h00; nedge(1);
        drive_expect(8'h10, 8'h10);
        drain("bounce");
        nedge(5);
        check_out("bounce", 8'h10, 1'b1);

        // Multi-press is rejected, partial release still rejected.
        bus.btn = 8'h00;
        nedge(10);
        bus.btn = 8'h21;
        nedge(12);
        check_out("multi", 8'h10, 1'b1);
        bus.btn = 8'h20;
        nedge(12);
        check_out("multi_partial", 8'h10, 1'b1);
        bus.btn = 8'h00;
        nedge(10);
        drive_expect(8'h04, 8'h04);
        drain("after_multi");
        check_out("after_multi", 8'h04, 1'b1);

        // Second button while held is ignored until all are released.
        bus.btn = 8'h00;
        nedge(10);
        drive_expect(8'h80, 8'h80);
        drain("held80");
        bus.btn = 8'h82;
        nedge(10);
        bus.btn = 8'h02;
        nedge(12);
        check_out("held_second", 8'h80, 1'b1);
        bus.btn = 8'h00;
        nedge(10);
        drive_expect(8'h02, 8'h02);
        drain("repress02");

        // Clear while valid; state stays HELD so no recapture of the held button.
        bus.clear = 1'b1;
        nedge(1);
        bus.clear = 1'b0;
        check_out("clear", 8'h00, 1'b0);
        nedge(10);
        check_out("clear_held", 8'h00, 1'b0);

        // Clear coinciding with a capture: capture wins.
        bus.btn = 8'h00;
        nedge(10);
        drive_expect(8'h02, 8'h02);
        nedge(LAT - 1);
        bus.clear = 1'b1;
        nedge(1);
        bus.clear = 1'b0;
        drain("clear_vs_capture");
        nedge(1);
        check_out("clear_vs_capture", 8'h02, 1'b1);

        bus.btn = 8'h00;
        nedge(10);
        n_vec++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL final_queue: %0d outstanding, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_onehot_latch.md
# button_onehot_latch

Upstream input stage for the one-hot-to-seven-segment display digit. Takes eight raw, bouncing, active-high push-buttons and conditions them. Latches the most recent valid single-button press as an 8-bit one-hot code on `dout`, which feeds the display digit's `din` directly. Multi-button presses are rejected, so the digit only ever sees a one-hot or all-zero code.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `btn`  in  8: raw button levels, asynchronous to `clk`; bit 7 = button 1 … bit 0 = button 8.
- `clear`  in  1: synchronous request to blank the latched code.
- `dout`  out  8: latched one-hot code, or 8'h00 when nothing is latched.
- `valid`  out  1: high while `dout` holds a latched press.
- `press`  out  1: one-cycle pulse when a new press is latched.

## Operation
- **Synchronizer:** each `btn` bit passes through a 2-FF synchronizer, giving `btn_s`.
- **Per-bit debouncer:**
  - Holds a `stable` level and a counter.
  - When `btn_s != stable`, the counter increments.
  - When `btn_s == stable`, the counter clears.
  - When the counter is at DEBOUNCE_CYCLES-1 and there is still a mismatch, `stable` toggles and the counter clears.
  - Net effect: a level is accepted after exactly DEBOUNCE_CYCLES consecutive mismatching cycles.
- **FSM:** operates on the 8-bit `stable` vector `S`. States are IDLE, HELD and REJECT.
  - IDLE, S == 0: stay in IDLE.
  - IDLE, S exactly one-hot: `dout <= S`, `valid <= 1`, pulse `press`, go to HELD.
  - IDLE, S nonzero but not one-hot: go to REJECT. No capture; `dout` unchanged.
  - HELD: no new capture while any bit is set. When S == 0, go to IDLE; `dout` is retained.
  - REJECT: when S == 0, go to IDLE. No output change.
  - A second button pressed while in HELD is ignored, even after the first is released, until S returns to 0. Changing the selection requires releasing all buttons.
- **Clear:**
  - `clear` high sets `dout <= 0` and `valid <= 0`. It does not change the FSM state or the debouncers.
  - If `clear` and a capture occur in the same cycle, the capture wins (`dout = S`, `valid = 1`, `press = 1`).
- **Reset:**
  - `dout = 8'h00`, `valid = 0`, `press = 0`, state IDLE.
  - All `stable = 0`, counters = 0, synchronizer flops = 0.
  - Reset asserted mid-debounce or mid-press aborts immediately. After release, a button still held is re-qualified from scratch and captured once it passes debounce.

## Timing
- A `btn` edge sampled at cycle 0 appears on `btn_s` at cycle 2.
- `stable` updates at the end of cycle 2+DEBOUNCE_CYCLES-1, provided the level held throughout.
- `dout`, `valid` and `press` update on the next edge, giving latency 2+DEBOUNCE_CYCLES+1 cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles (as seen on `btn_s`) produces no change.
- `press` is high for exactly one cycle per capture. `clear` takes effect on the next edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `btn_pkg` holds:
  - the FSM state enum `{IDLE, HELD, REJECT}`;
  - the one-hot check function `is_onehot(logic [7:0])`;
  - the constant `NUM_BTN = 8`.
- Sub-module `debounce_bit`, instantiated 8×, contains the synchronizer, counter and `stable` register, parameterized by DEBOUNCE_CYCLES/CNT_W.
- The top level holds the FSM and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. **Reset:** assert `rst` async mid-cycle with `btn=8'h20` -> `dout=00`, `valid=0`, `press=0` immediately. After release with `btn` still 8'h20 -> `dout=20`, `press` pulse at cycle 7 after release.
2. **Clean press:** `btn=8'h20` from cycle 0 -> `dout=20`, `valid=1`, one-cycle `press` at cycle 7. Release, then `btn=8'h01` -> `dout=01` with a new `press`.
3. **Bounce:** `btn` bit 4 toggles 1,0,1,0 every cycle, then holds 1 -> exactly one `press`, `dout=10`, 7 cycles after the final stable edge.
4. **Multi-press:** `btn=8'h21` -> state REJECT, `dout` keeps its prior value, no `press`. Release bit 0 only -> still no capture. Release all, then press 8'h04 -> `dout=04`.
5. **Held second button:** hold 8'h80 (captured), add bit 1, release bit 7 -> `dout` stays 80, no `press`, until all buttons are released and re-pressed.
6. **Clear:** `clear` while `valid` -> next cycle `dout=00`, `valid=0`. `clear` in the same cycle as a capture of 8'h02 -> `dout=02`, `valid=1`, `press=1`.
